// File: rtl/prod_acc_pkg.sv
// Shared types and default widths for the product accumulator.
package prod_acc_pkg;

  localparam int PROD_W_DEF = 32;
  localparam int ACC_W_DEF  = 40;
  localparam int LEN_W_DEF  = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/prod_acc_sat_add.sv
// Combinational saturating add of a zero-extended product onto the accumulator.
module prod_acc_sat_add
  import prod_acc_pkg::*;
#(
  parameter int PROD_W = PROD_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic [ACC_W-1:0]  acc_in,
  input  logic [PROD_W-1:0] prod_in,
  output logic [ACC_W-1:0]  sum_out,
  output logic              ovf_out
);

  logic [ACC_W:0] sum_full;

  always_comb begin
    sum_full = {1'b0, acc_in} + (ACC_W+1)'(prod_in);
    ovf_out  = sum_full[ACC_W];
    sum_out  = sum_full[ACC_W] ? {ACC_W{1'b1}} : sum_full[ACC_W-1:0];
  end

endmodule

// File: rtl/prod_accumulator.sv
// Frame-based accumulator of unsigned multiplier products with saturation.
// state   | meaning
// IDLE    | waiting for start with a non-zero length; last result held
// ACC     | accepting products until the frame length is consumed
// DONE    | frame sum presented until downstream takes it
module prod_accumulator
  import prod_acc_pkg::*;
#(
  parameter int PROD_W = PROD_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] prod,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  acc,
  output logic              ovf
);

  state_e            state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic              ovf_q, ovf_d;
  logic [LEN_W-1:0]  rem_q, rem_d;

  logic [ACC_W-1:0]  sum_sat;
  logic              sum_ovf;
  logic              beat;

  prod_acc_sat_add #(
    .PROD_W (PROD_W),
    .ACC_W  (ACC_W)
  ) u_sat_add (
    .acc_in  (acc_q),
    .prod_in (prod),
    .sum_out (sum_sat),
    .ovf_out (sum_ovf)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    rem_d   = rem_q;
    beat    = in_valid && (state_q == ST_ACC);

    if (clr) begin
      state_d = ST_IDLE;
      acc_d   = '0;
      ovf_d   = 1'b0;
      rem_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start && (len != '0)) begin
            state_d = ST_ACC;
            acc_d   = '0;
            ovf_d   = 1'b0;
            rem_d   = len;
          end
        end
        ST_ACC: begin
          if (beat) begin
            acc_d = sum_sat;
            ovf_d = ovf_q | sum_ovf;
            rem_d = rem_q - LEN_W'(1);
            if (rem_q == LEN_W'(1)) state_d = ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      rem_q   <= rem_d;
    end
  end

  // Handshake outputs come from state alone so in_valid/out_ready never reach them.
  assign in_ready  = (state_q == ST_ACC);
  assign out_valid = (state_q == ST_DONE);
  assign acc       = acc_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_prod_accumulator.sv
// Bench for prod_accumulator: default-width and 33-bit instances share stimulus
// and are compared every cycle against a frame-level reference model.
module tb_prod_accumulator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  len = '0;
  logic        in_valid = 1'b0;
  logic [31:0] prod = '0;
  logic        out_ready = 1'b0;

  logic        in_ready40, out_valid40, ovf40;
  logic [39:0] acc40;
  logic        in_ready33, out_valid33, ovf33;
  logic [32:0] acc33;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  prod_accumulator dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready40), .prod(prod),
    .out_valid(out_valid40), .out_ready(out_ready), .acc(acc40), .ovf(ovf40)
  );

  prod_accumulator #(.ACC_W(33)) dut33 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready33), .prod(prod),
    .out_valid(out_valid33), .out_ready(out_ready), .acc(acc33), .ovf(ovf33)
  );

  // Reference model: phase 0 = waiting, 1 = collecting, 2 = result offered.
  localparam logic [64:0] MAX40 = (65'd1 << 40) - 65'd1;
  localparam logic [64:0] MAX33 = (65'd1 << 33) - 65'd1;
  int          m_phase = 0;
  int          m_rem = 0;
  logic [64:0] m_acc40 = '0, m_acc33 = '0;
  bit          m_ovf40 = 1'b0, m_ovf33 = 1'b0;

  task automatic model_reset();
    m_phase = 0; m_rem = 0;
    m_acc40 = '0; m_acc33 = '0;
    m_ovf40 = 1'b0; m_ovf33 = 1'b0;
  endtask

  task automatic model_step();
    logic [64:0] s;
    if (clr) begin
      model_reset();
    end else if (m_phase == 0) begin
      if (start && len != 0) begin
        model_reset();
        m_phase = 1;
        m_rem = int'(len);
      end
    end else if (m_phase == 1) begin
      if (in_valid) begin
        s = m_acc40 + 65'(prod);
        if (s > MAX40) begin m_acc40 = MAX40; m_ovf40 = 1'b1; end else m_acc40 = s;
        s = m_acc33 + 65'(prod);
        if (s > MAX33) begin m_acc33 = MAX33; m_ovf33 = 1'b1; end else m_acc33 = s;
        m_rem = m_rem - 1;
        if (m_rem == 0) m_phase = 2;
      end
    end else begin
      if (out_ready) m_phase = 0;
    end
  endtask

  always @(posedge clk) if (rst_n) model_step();

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("in_ready40",  64'(in_ready40),  64'(m_phase == 1));
    chk("out_valid40", 64'(out_valid40), 64'(m_phase == 2));
    chk("acc40",       64'(acc40),       m_acc40[63:0]);
    chk("ovf40",       64'(ovf40),       64'(m_ovf40));
    chk("in_ready33",  64'(in_ready33),  64'(m_phase == 1));
    chk("out_valid33", 64'(out_valid33), 64'(m_phase == 2));
    chk("acc33",       64'(acc33),       m_acc33[63:0]);
    chk("ovf33",       64'(ovf33),       64'(m_ovf33));
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic start_frame(input int n);
    start = 1'b1; len = 8'(n);
    tick();
    start = 1'b0;
  endtask

  task automatic beat(input logic [31:0] p);
    in_valid = 1'b1; prod = p;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    #3;
    chk("rst_in_ready",  64'(in_ready40),  64'd0);
    chk("rst_out_valid", 64'(out_valid40), 64'd0);
    chk("rst_acc",       64'(acc40),       64'd0);
    chk("rst_ovf",       64'(ovf33),       64'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Three consecutive beats
    start_frame(3);
    beat(32'd6); in_valid = 1'b1; prod = 32'd20; tick(); prod = 32'd100; tick(); in_valid = 1'b0;
    chk("seq_out_valid", 64'(out_valid40), 64'd1);
    chk("seq_acc",       64'(acc40),       64'd126);
    chk("seq_ovf",       64'(ovf40),       64'd0);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    chk("seq_idle",      64'(out_valid40), 64'd0);
    chk("seq_hold",      64'(acc40),       64'd126);

    // Gapped beats, in_ready held through the gap
    start_frame(2);
    beat(32'd65025);
    for (int i = 0; i < 3; i++) begin
      chk("gap_in_ready", 64'(in_ready40), 64'd1);
      tick();
    end
    beat(32'd65025);
    chk("gap_acc", 64'(acc40), 64'd130050);
    out_ready = 1'b1; tick(); out_ready = 1'b0;

    // Saturation on the 33-bit instance
    start_frame(3);
    repeat (3) beat(32'hFFFF_FFFF);
    chk("sat_acc33", 64'(acc33), 64'h1_FFFF_FFFF);
    chk("sat_ovf33", 64'(ovf33), 64'd1);
    chk("sat_acc40", 64'(acc40), 64'h2_FFFF_FFFD);
    chk("sat_ovf40", 64'(ovf40), 64'd0);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    chk("sat_ovf_idle", 64'(ovf33), 64'd1);
    start_frame(1);
    chk("sat_ovf_cleared", 64'(ovf33), 64'd0);
    beat(32'd9);

    // Downstream stall; start pulses must be ignored
    for (int i = 0; i < 5; i++) begin
      start = i[0]; len = 8'd2;
      tick();
      chk("stall_valid", 64'(out_valid40), 64'd1);
      chk("stall_acc",   64'(acc40),       64'd9);
    end
    start = 1'b0;
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    chk("stall_release", 64'(out_valid40), 64'd0);

    // Back-to-back: start on the single IDLE cycle after handshake
    start_frame(1);
    chk("b2b_in_ready", 64'(in_ready40), 64'd1);
    beat(32'd4);
    out_ready = 1'b1; tick(); out_ready = 1'b0;

    // clr with a simultaneous beat
    start_frame(4);
    beat(32'd7); beat(32'd9);
    clr = 1'b1; in_valid = 1'b1; prod = 32'd5; start = 1'b1; len = 8'd3;
    tick();
    clr = 1'b0; in_valid = 1'b0; start = 1'b0;
    chk("clr_in_ready", 64'(in_ready40), 64'd0);
    chk("clr_acc",      64'(acc40),      64'd0);
    repeat (3) begin
      tick();
      chk("clr_no_valid", 64'(out_valid40), 64'd0);
    end

    // Asynchronous reset mid-frame
    start_frame(4);
    beat(32'd11); beat(32'd13);
    rst_n = 1'b0; model_reset();
    #1;
    chk("arst_in_ready", 64'(in_ready40), 64'd0);
    chk("arst_acc",      64'(acc40),      64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Zero-length start
    start_frame(0);
    chk("len0_in_ready", 64'(in_ready40), 64'd0);
    chk("len0_acc",      64'(acc40),      64'd0);

    // Randomised traffic
    for (int i = 0; i < 2000; i++) begin
      clr       = ($urandom_range(0, 49) == 0);
      start     = ($urandom_range(0, 3) == 0);
      len       = 8'($urandom_range(0, 6));
      in_valid  = ($urandom_range(0, 2) != 0);
      prod      = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : 32'($urandom());
      out_ready = ($urandom_range(0, 2) == 0);
      tick();
    end
    clr = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
